// File: rtl/rcvr_pkg.sv
// Shared types and constants for the serial receiver drain path.
// State encoding, default sizing and the frame header byte agreed with the receiver.
package rcvr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rcvr_state_t;

  localparam logic [7:0] RCVR_HDR  = 8'hA5;
  localparam int         DEF_DEPTH = 4;
  localparam int         DEF_CNT_W = 8;

endpackage

// File: rtl/rcvr_drain_ctrl_if.sv
// Receiver-facing and consumer-facing signals of the drain controller.
// master = the controller, slave = the receiver/consumer environment.
interface rcvr_drain_ctrl_if;

  logic       rx_ready;
  logic       rx_overrun;
  logic [7:0] rx_data;
  logic       rx_reading;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_accept;

  modport master (
    input  rx_ready, rx_overrun, rx_data, out_accept,
    output rx_reading, out_valid, out_data
  );

  modport slave (
    output rx_ready, rx_overrun, rx_data, out_accept,
    input  rx_reading, out_valid, out_data
  );

endinterface

// File: rtl/rcvr_sync_fifo.sv
// DEPTH x W synchronous FIFO with a registered head word; written entries are visible one cycle after push.
// Caller must not push when full unless popping the same cycle, and must not pop when empty.
module rcvr_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head_dat
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    ONE      = (AW+1)'(1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;

  assign rd_nxt = rd_ptr + AW'(1);
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      // Head tracks the oldest entry; with one entry left, a same-cycle push becomes the new head.
      if (pop) begin
        if (count > ONE) begin
          head_dat <= mem[rd_nxt];
        end else if (push) begin
          head_dat <= push_dat;
        end
      end else if (push && empty) begin
        head_dat <= push_dat;
      end
    end
  end

endmodule

// File: rtl/rcvr_drain_ctrl.sv
// Drains the serial receiver one byte per two cycles into a FIFO and keeps saturating overrun statistics.
// Full FIFO stalls the receiver unless RCVR_DRAIN_DROP_EN is defined, which drains and discards instead.
module rcvr_drain_ctrl
  import rcvr_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  rcvr_drain_ctrl_if.master        bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ovr_count,
  output logic                     ovr_sticky
`ifdef RCVR_DRAIN_DROP_EN
  ,
  output logic [CNT_W-1:0]         drop_count
`endif
);

  rcvr_state_t state;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        full_eff;
  logic        ovr_q;
  logic [7:0]  head_dat;

  // A pop frees a slot at the same edge, so a push is legal even at full.
  assign pop           = bus.out_valid && bus.out_accept;
  assign full_eff      = fifo_full && !pop;
  assign push          = (state == IDLE) && bus.rx_ready && !full_eff;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_dat;

  rcvr_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.rx_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_dat (head_dat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bus.rx_reading <= 1'b0;
`ifdef RCVR_DRAIN_DROP_EN
      drop_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_ready && !full_eff) begin
            bus.rx_reading <= 1'b1;
            state          <= ACK;
`ifdef RCVR_DRAIN_DROP_EN
          end else if (bus.rx_ready) begin
            bus.rx_reading <= 1'b1;
            state          <= ACK;
            if (~&drop_count) begin
              drop_count <= drop_count + 1'b1;
            end
`endif
          end else begin
            bus.rx_reading <= 1'b0;
          end
        end
        ACK: begin
          // Receiver drops ready at this edge, so the next IDLE sees fresh status.
          bus.rx_reading <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_q      <= 1'b0;
      ovr_count  <= '0;
      ovr_sticky <= 1'b0;
    end else begin
      ovr_q <= bus.rx_overrun;
      if (bus.rx_overrun && !ovr_q) begin
        ovr_sticky <= 1'b1;
        if (~&ovr_count) begin
          ovr_count <= ovr_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcvr_drain_ctrl.sv
// Bench for rcvr_drain_ctrl: behavioural receiver, scoreboard on the consumer side.
// Build with RCVR_DRAIN_DROP_EN defined to also exercise the discard path.
module tb_rcvr_drain_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] fifo_count;
  logic [7:0] ovr_count;
  logic       ovr_sticky;
`ifdef RCVR_DRAIN_DROP_EN
  logic [7:0] drop_count;
`endif

  int         checks    = 0;
  int         errors    = 0;
  int         pulse_cnt = 0;
  logic       prev_rd   = 1'b0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  rcvr_drain_ctrl_if bus ();

  rcvr_drain_ctrl #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .fifo_count (fifo_count),
    .ovr_count  (ovr_count),
    .ovr_sticky (ovr_sticky)
`ifdef RCVR_DRAIN_DROP_EN
    ,
    .drop_count (drop_count)
`endif
  );

  // Receiver model: drops ready once it sees the drain pulse, then offers the next queued byte.
  always @(posedge clock) begin
    #1;
    if (bus.rx_reading) bus.rx_ready = 1'b0;
    if (!bus.rx_ready && src_q.size() > 0) begin
      bus.rx_data  = src_q.pop_front();
      bus.rx_ready = 1'b1;
    end
  end

  // Consumer-side scoreboard and drain-pulse width monitor.
  always @(negedge clock) begin
    if (bus.rx_reading) begin
      pulse_cnt++;
      checks++;
      if (prev_rd) begin
        errors++;
        $display("FAIL rx_reading_width: high on consecutive cycles at %0t, required one-cycle pulse", $time);
      end
    end
    prev_rd = bus.rx_reading;
    if (!reset && bus.out_valid && bus.out_accept) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: popped %02h with nothing expected", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %02h, required %02h", bus.out_data, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.out_accept = 1'b0;
    bus.rx_overrun = 1'b0;
    bus.rx_ready   = 1'b0;
    step(2);
    src_q.delete();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    src_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_empty(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && src_q.size() == 0 && !bus.rx_ready && fifo_count == 3'd0) begin
        done = 1'b1;
        break;
      end
      step(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: timeout, fifo_count=%0d pending=%0d, required all drained", name, fifo_count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    @(negedge clock);
    checks++; if (bus.rx_reading !== 1'b0) begin errors++; $display("FAIL rst_reading: got %b, required 0", bus.rx_reading); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, required 00", bus.out_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", fifo_count); end
    checks++; if (ovr_count !== 8'd0 || ovr_sticky !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %0d/%b, required 0/0", ovr_count, ovr_sticky); end
    do_reset();
  endtask

  task automatic test_single();
    bit seen = 1'b0;
    do_reset();
    bus.out_accept = 1'b1;
    send(8'h3C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.rx_ready) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_ready: receiver never offered byte, required ready"); end
    checks++; if (bus.rx_reading !== 1'b0) begin errors++; $display("FAIL single_early: rx_reading %b before sampling, required 0", bus.rx_reading); end
    @(negedge clock);
    checks++; if (bus.rx_reading !== 1'b1) begin errors++; $display("FAIL single_pulse: rx_reading %b, required 1", bus.rx_reading); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin errors++; $display("FAIL single_out: valid=%b data=%02h, required 1/3c", bus.out_valid, bus.out_data); end
    @(negedge clock);
    checks++; if (bus.rx_reading !== 1'b0) begin errors++; $display("FAIL single_pulse_end: rx_reading %b, required 0", bus.rx_reading); end
    checks++; if (fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: count=%0d valid=%b, required 0/0", fifo_count, bus.out_valid); end
    wait_empty(10, "single");
  endtask

  task automatic test_fill();
    int base;
    do_reset();
    base = pulse_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i));
    step(20);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d, required 4", fifo_count); end
    checks++; if (pulse_cnt - base != 4) begin errors++; $display("FAIL fill_pulses: got %0d, required 4", pulse_cnt - base); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL fill_stall: rx_ready %b, required 1 (byte held)", bus.rx_ready); end
    checks++; if (bus.out_data !== 8'h01) begin errors++; $display("FAIL fill_head: got %02h, required 01", bus.out_data); end
    bus.rx_overrun = 1'b1;
    step(1);
    bus.rx_overrun = 1'b0;
    step(1);
    checks++; if (ovr_count !== 8'd1 || ovr_sticky !== 1'b1) begin errors++; $display("FAIL fill_ovr: got %0d/%b, required 1/1", ovr_count, ovr_sticky); end
    bus.out_accept = 1'b1;
    wait_empty(40, "fill");
    checks++; if (pulse_cnt - base != 5) begin errors++; $display("FAIL fill_pulses_end: got %0d, required 5", pulse_cnt - base); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    step(12);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_fill: got %0d, required 4", fifo_count); end
    send(8'h14);
    step(3);
    bus.out_accept = 1'b1;
    step(1);
    bus.out_accept = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_count: got %0d, required 4", fifo_count); end
    checks++; if (bus.rx_reading !== 1'b1) begin errors++; $display("FAIL simul_pulse: rx_reading %b, required 1", bus.rx_reading); end
    @(posedge clock); #2;
    bus.out_accept = 1'b1;
    wait_empty(40, "simul");
  endtask

  task automatic test_overrun_level();
    do_reset();
    bus.rx_overrun = 1'b1;
    step(10);
    bus.rx_overrun = 1'b0;
    step(2);
    repeat (2) begin
      bus.rx_overrun = 1'b1; step(1);
      bus.rx_overrun = 1'b0; step(2);
    end
    checks++; if (ovr_count !== 8'd3 || ovr_sticky !== 1'b1) begin errors++; $display("FAIL ovr_level: got %0d/%b, required 3/1", ovr_count, ovr_sticky); end
    repeat (300) begin
      bus.rx_overrun = 1'b1; step(1);
      bus.rx_overrun = 1'b0; step(1);
    end
    checks++; if (ovr_count !== 8'd255) begin errors++; $display("FAIL ovr_sat: got %0d, required 255", ovr_count); end
  endtask

  task automatic test_reset_ack();
    bit hit = 1'b0;
    do_reset();
    bus.rx_overrun = 1'b1; step(1);
    bus.rx_overrun = 1'b0; step(1);
    send(8'h21);
    send(8'h22);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rx_reading && fifo_count == 3'd2) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rack_setup: never saw ACK with 2 buffered, count=%0d", fifo_count); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.rx_reading !== 1'b0) begin errors++; $display("FAIL rack_reading: got %b, required 0", bus.rx_reading); end
    checks++; if (fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rack_fifo: count=%0d valid=%b, required 0/0", fifo_count, bus.out_valid); end
    checks++; if (ovr_count !== 8'd0 || ovr_sticky !== 1'b0) begin errors++; $display("FAIL rack_ovr: got %0d/%b, required 0/0", ovr_count, ovr_sticky); end
    @(posedge clock); #2;
    reset = 1'b0;
    exp_q.delete();
    bus.out_accept = 1'b1;
    send(8'h77);
    wait_empty(20, "rack");
  endtask

`ifdef RCVR_DRAIN_DROP_EN
  task automatic test_drop();
    int base;
    do_reset();
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
    src_q.push_back(8'h41);
    src_q.push_back(8'h42);
    src_q.push_back(8'h43);
    step(30);
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL drop_count: got %0d, required 3", drop_count); end
    checks++; if (pulse_cnt - base != 7) begin errors++; $display("FAIL drop_pulses: got %0d, required 7", pulse_cnt - base); end
    checks++; if (bus.rx_ready !== 1'b0 || src_q.size() != 0) begin errors++; $display("FAIL drop_rx: ready=%b pending=%0d, required 0/0", bus.rx_ready, src_q.size()); end
    checks++; if (fifo_count !== 3'd4 || bus.out_data !== 8'h31) begin errors++; $display("FAIL drop_fifo: count=%0d head=%02h, required 4/31", fifo_count, bus.out_data); end
    bus.out_accept = 1'b1;
    wait_empty(30, "drop");
  endtask
`endif

  initial begin
    bus.rx_ready   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_overrun = 1'b0;
    bus.out_accept = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_overrun_level();
    test_reset_ack();
`ifdef RCVR_DRAIN_DROP_EN
    test_drop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
